// File: rtl/qed_dup_issue_if.sv
// Bundle of the instruction-in / instruction-out signals of the duplicating issue stage.
// master drives the candidate instruction and controls; slave is the issue stage itself.
interface qed_dup_issue_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      ifu_qed_instruction;
    logic             exec_dup;
    logic             stall_IF;
    logic [31:0]      qed_ifu_instruction;
    logic             vld_out;
    logic             qed_ready;
    logic             fifo_full;
    logic             illegal_inst;
    logic [CNT_W-1:0] dbg_count;

    // No valid/ready handshake: an input is consumed at every edge with stall_IF = 0,
    // and qed_ifu_instruction is meaningful exactly when vld_out = 1.
    modport master (
        output ifu_qed_instruction, exec_dup, stall_IF,
        input  qed_ifu_instruction, vld_out, qed_ready, fifo_full, illegal_inst, dbg_count
    );

    modport slave (
        input  ifu_qed_instruction, exec_dup, stall_IF,
        output qed_ifu_instruction, vld_out, qed_ready, fifo_full, illegal_inst, dbg_count
    );
endinterface

// File: rtl/qed_dup_issue.sv
// SQED duplicating issue stage: forwards legal originals while queueing their
// register/memory-remapped duplicates, then replays the duplicates in order.
module qed_dup_issue #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] NOP_INST = 32'h0000007F
) (
    input  logic           clk,
    input  logic           rst,
    qed_dup_issue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      inst_q, inst_d;
    logic             vld_q, vld_d;
    logic             illegal_q, illegal_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_q [DEPTH];

    logic [31:0] in_inst;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        is_ialu, is_ralu, is_lw, is_sw, is_nop, legal;
    logic        q_empty, q_full, push;
    logic [31:0] dup_inst;

    assign in_inst = bus.ifu_qed_instruction;
    assign opcode  = in_inst[6:0];
    assign rd      = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1     = in_inst[19:15];
    assign rs2     = in_inst[24:20];
    assign funct7  = in_inst[31:25];

    // Originals may only touch x0..x15 so their duplicates can own x16..x31.
    always_comb begin
        is_ialu = 1'b0;
        is_ralu = 1'b0;
        if (opcode == 7'b0010011 && !rs1[4] && !rd[4]) begin
            unique case (funct3)
                3'b001:  is_ialu = (funct7 == 7'b0000000);
                3'b101:  is_ialu = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                default: is_ialu = 1'b1;
            endcase
        end
        if (opcode == 7'b0110011 && !rs1[4] && !rs2[4] && !rd[4]) begin
            unique case (funct7)
                7'b0000000: is_ralu = 1'b1;
                7'b0100000: is_ralu = (funct3 == 3'b000) || (funct3 == 3'b101);
                7'b0000001: is_ralu = !funct3[2];
                default:    is_ralu = 1'b0;
            endcase
        end
    end

    assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010) && (rs1 == 5'd0) &&
                    (in_inst[31:30] == 2'b00) && !rd[4];
    assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010) && (rs1 == 5'd0) &&
                    (in_inst[31:30] == 2'b00) && !rs2[4];
    assign is_nop = (opcode == 7'b1111111);
    assign legal  = is_ialu || is_ralu || is_lw || is_sw || is_nop;

    // Bit 30 is immediate bit 10: duplicate memory traffic lands 1 KiB above the original.
    always_comb begin
        dup_inst = in_inst;
        if (is_ialu) begin
            dup_inst[19] = 1'b1;
            dup_inst[11] = 1'b1;
        end
        if (is_ralu) begin
            dup_inst[24] = 1'b1;
            dup_inst[19] = 1'b1;
            dup_inst[11] = 1'b1;
        end
        if (is_lw) begin
            dup_inst[30] = 1'b1;
            dup_inst[11] = 1'b1;
        end
        if (is_sw) begin
            dup_inst[30] = 1'b1;
            dup_inst[24] = 1'b1;
        end
    end

    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        inst_d    = inst_q;
        vld_d     = vld_q;
        illegal_d = illegal_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        push      = 1'b0;
        if (!bus.stall_IF) begin
            inst_d    = NOP_INST;
            vld_d     = 1'b0;
            illegal_d = 1'b0;
            if (!bus.exec_dup) begin
                illegal_d = !legal;
                if (legal && !is_nop && !q_full) begin
                    push    = 1'b1;
                    inst_d  = in_inst;
                    vld_d   = 1'b1;
                    wptr_d  = wptr_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(1);
                end
            end else if (!q_empty) begin
                inst_d  = mem_q[rptr_q];
                vld_d   = 1'b1;
                rptr_d  = rptr_q + PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q    <= NOP_INST;
            vld_q     <= 1'b0;
            illegal_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            inst_q    <= inst_d;
            vld_q     <= vld_d;
            illegal_q <= illegal_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= dup_inst;
        end
    end

    assign bus.qed_ifu_instruction = inst_q;
    assign bus.vld_out             = vld_q;
    assign bus.illegal_inst        = illegal_q;
    assign bus.qed_ready           = q_empty;
    assign bus.fifo_full           = q_full;
    assign bus.dbg_count           = count_q;
endmodule

// File: tb/tb_qed_dup_issue.sv
// Bench for qed_dup_issue: directed scenarios plus a randomized run against a
// queue-based reference model that works on decoded instruction fields.
module tb_qed_dup_issue;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000007F;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] exp_q[$];
    logic [31:0] m_out;
    logic        m_vld;
    logic        m_ill;

    qed_dup_issue_if #(.DEPTH(DEPTH)) bus ();

    qed_dup_issue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legality straight from the instruction tables: mnemonic sets by (opcode, funct3, funct7).
    function automatic logic model_legal(input logic [31:0] inst);
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        rd  = inst[11:7];
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        f3  = inst[14:12];
        f7  = inst[31:25];
        case (inst[6:0])
            7'h13: return (rs1 < 16) && (rd < 16) &&
                          ((f3 inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) ||
                           (f3 == 3'd1 && f7 == 7'h00) ||
                           (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
            7'h33: return (rs1 < 16) && (rs2 < 16) && (rd < 16) &&
                          ((f7 == 7'h00) ||
                           (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                           (f7 == 7'h01 && f3 <= 3'd3));
            7'h03: return (f3 == 3'd2) && (rs1 == 0) && (inst[31:20] < 12'd1024) && (rd < 16);
            7'h23: return (f3 == 3'd2) && (rs1 == 0) && ({inst[31:25], inst[11:7]} < 12'd1024) &&
                          (rs2 < 16);
            7'h7F: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Duplicate rebuilt from fields: registers moved up by 16, memory offset plus 1024.
    function automatic logic [31:0] model_dup(input logic [31:0] inst);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        rd  = inst[11:7];
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        case (inst[6:0])
            7'h13: return {inst[31:20], rs1 + 5'd16, inst[14:12], rd + 5'd16, inst[6:0]};
            7'h33: return {inst[31:25], rs2 + 5'd16, rs1 + 5'd16, inst[14:12], rd + 5'd16, inst[6:0]};
            7'h03: begin
                imm = inst[31:20] + 12'd1024;
                return {imm, 5'd0, inst[14:12], rd + 5'd16, inst[6:0]};
            end
            7'h23: begin
                imm = {inst[31:25], inst[11:7]} + 12'd1024;
                return {imm[11:5], rs2 + 5'd16, 5'd0, inst[14:12], imm[4:0], inst[6:0]};
            end
            default: return inst;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3, mf3;
        logic [6:0]  f7;
        logic [11:0] imm, iimm;
        rd  = 5'($urandom_range(0, 19));
        rs1 = 5'($urandom_range(0, 19));
        rs2 = 5'($urandom_range(0, 19));
        f3  = 3'($urandom_range(0, 7));
        mf3 = ($urandom_range(0, 5) == 0) ? f3 : 3'd2;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        imm = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {2'b00, 10'($urandom)};
        iimm = (f3 == 3'd1 || f3 == 3'd5) ? {f7, imm[4:0]} : imm;
        case ($urandom_range(0, 9))
            0, 1: return {f7, rs2, rs1, f3, rd, 7'h33};
            2, 3: return {iimm, rs1, f3, rd, 7'h13};
            4:    return {imm, (($urandom_range(0, 3) == 0) ? rs1 : 5'd0), mf3, rd, 7'h03};
            5:    return {imm[11:5], rs2, (($urandom_range(0, 3) == 0) ? rs1 : 5'd0), mf3, imm[4:0], 7'h23};
            6:    return {25'($urandom), 7'h7F};
            default: return $urandom;
        endcase
    endfunction

    // Advance one edge with the inputs currently applied and update the model.
    task automatic tick();
        logic        r, s, d, ok;
        logic [31:0] in;
        r  = rst;
        s  = bus.stall_IF;
        d  = bus.exec_dup;
        in = bus.ifu_qed_instruction;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_out = NOP;
            m_vld = 1'b0;
            m_ill = 1'b0;
        end else if (!s) begin
            if (d) begin
                m_ill = 1'b0;
                if (exp_q.size() > 0) begin
                    m_out = exp_q.pop_front();
                    m_vld = 1'b1;
                end else begin
                    m_out = NOP;
                    m_vld = 1'b0;
                end
            end else begin
                ok    = model_legal(in);
                m_ill = !ok;
                if (ok && in[6:0] != 7'h7F && exp_q.size() < DEPTH) begin
                    m_out = in;
                    m_vld = 1'b1;
                    exp_q.push_back(model_dup(in));
                end else begin
                    m_out = NOP;
                    m_vld = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (bus.qed_ifu_instruction !== NOP) begin n_err++; $display("FAIL reset_inst got %h want %h", bus.qed_ifu_instruction, NOP); end
        n_vec++; if (bus.vld_out !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", bus.vld_out); end
        n_vec++; if (bus.illegal_inst !== 1'b0) begin n_err++; $display("FAIL reset_ill got %b want 0", bus.illegal_inst); end
        n_vec++; if (bus.qed_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.qed_ready); end
        n_vec++; if (bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
    endtask

    task automatic test_rtype();
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h003100B3;
        tick();
        n_vec++; if (bus.qed_ifu_instruction !== 32'h003100B3) begin n_err++; $display("FAIL rtype_orig got %h want 003100b3", bus.qed_ifu_instruction); end
        n_vec++; if (bus.vld_out !== 1'b1 || bus.qed_ready !== 1'b0) begin n_err++; $display("FAIL rtype_orig_flags got vld=%b rdy=%b want vld=1 rdy=0", bus.vld_out, bus.qed_ready); end
        bus.exec_dup = 1'b1;
        tick();
        n_vec++; if (bus.qed_ifu_instruction !== 32'h013908B3) begin n_err++; $display("FAIL rtype_dup got %h want 013908b3", bus.qed_ifu_instruction); end
        n_vec++; if (bus.vld_out !== 1'b1 || bus.qed_ready !== 1'b1) begin n_err++; $display("FAIL rtype_dup_flags got vld=%b rdy=%b want vld=1 rdy=1", bus.vld_out, bus.qed_ready); end
    endtask

    task automatic test_memory();
        logic [31:0] want [3];
        want = '{32'h40802A83, 32'h41402623, NOP};
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h00802283;
        tick();
        bus.ifu_qed_instruction = 32'h00402623;
        tick();
        bus.exec_dup = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.qed_ifu_instruction !== want[i] || bus.vld_out !== (i < 2)) begin
                n_err++; $display("FAIL mem_dup%0d got %h vld=%b want %h vld=%b", i, bus.qed_ifu_instruction, bus.vld_out, want[i], (i < 2));
            end
        end
    endtask

    task automatic test_illegal_nop();
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h0000006F;
        tick();
        n_vec++; if (bus.qed_ifu_instruction !== NOP || bus.vld_out !== 1'b0 || bus.illegal_inst !== 1'b1) begin
            n_err++; $display("FAIL illegal_jal got %h vld=%b ill=%b want %h vld=0 ill=1", bus.qed_ifu_instruction, bus.vld_out, bus.illegal_inst, NOP);
        end
        n_vec++; if (bus.dbg_count !== 5'd0) begin n_err++; $display("FAIL illegal_count got %0d want 0", bus.dbg_count); end
        bus.ifu_qed_instruction = 32'h0000007F;
        tick();
        n_vec++; if (bus.qed_ifu_instruction !== NOP || bus.vld_out !== 1'b0 || bus.illegal_inst !== 1'b0) begin
            n_err++; $display("FAIL nop_in got %h vld=%b ill=%b want %h vld=0 ill=0", bus.qed_ifu_instruction, bus.vld_out, bus.illegal_inst, NOP);
        end
        n_vec++; if (bus.qed_ready !== 1'b1) begin n_err++; $display("FAIL nop_ready got %b want 1", bus.qed_ready); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] inst;
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h00500093;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_vec++; if (bus.vld_out !== 1'b1) begin n_err++; $display("FAIL fill_vld%0d got %b want 1", i, bus.vld_out); end
        end
        n_vec++; if (bus.fifo_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", bus.fifo_full); end
        tick();
        n_vec++; if (bus.vld_out !== 1'b0 || bus.qed_ifu_instruction !== NOP || bus.dbg_count !== 5'd16) begin
            n_err++; $display("FAIL overflow got %h vld=%b cnt=%0d want %h vld=0 cnt=16", bus.qed_ifu_instruction, bus.vld_out, bus.dbg_count, NOP);
        end
        bus.exec_dup = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_vec++; if (bus.qed_ifu_instruction !== 32'h00580893 || bus.vld_out !== 1'b1) begin
                n_err++; $display("FAIL drain%0d got %h vld=%b want 00580893 vld=1", i, bus.qed_ifu_instruction, bus.vld_out);
            end
        end
        n_vec++; if (bus.qed_ready !== 1'b1 || bus.fifo_full !== 1'b0) begin n_err++; $display("FAIL drained got rdy=%b full=%b want 1 0", bus.qed_ready, bus.fifo_full); end
        for (int r = 0; r < 8; r++) begin
            bus.exec_dup = 1'b0;
            for (int i = 0; i < 3; i++) begin
                inst = {12'($urandom), 1'b0, 4'($urandom), 3'd0, 1'b0, 4'($urandom), 7'h13};
                bus.ifu_qed_instruction = inst;
                tick();
                n_vec++; if (bus.qed_ifu_instruction !== inst || bus.vld_out !== 1'b1) begin
                    n_err++; $display("FAIL wrap_push r%0d got %h vld=%b want %h vld=1", r, bus.qed_ifu_instruction, bus.vld_out, inst);
                end
            end
            bus.exec_dup = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                n_vec++; if (bus.qed_ifu_instruction !== m_out || bus.vld_out !== 1'b1) begin
                    n_err++; $display("FAIL wrap_pop r%0d got %h vld=%b want %h vld=1", r, bus.qed_ifu_instruction, bus.vld_out, m_out);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] want [3];
        want = '{32'h013908B3, 32'h40802A83, NOP};
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h003100B3;
        tick();
        bus.ifu_qed_instruction = 32'h00802283;
        tick();
        bus.stall_IF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.exec_dup = 1'($urandom);
            bus.ifu_qed_instruction = 32'h00500093;
            tick();
            n_vec++; if (bus.qed_ifu_instruction !== 32'h00802283 || bus.vld_out !== 1'b1 || bus.dbg_count !== 5'd2) begin
                n_err++; $display("FAIL stall%0d got %h vld=%b cnt=%0d want 00802283 vld=1 cnt=2", i, bus.qed_ifu_instruction, bus.vld_out, bus.dbg_count);
            end
        end
        bus.stall_IF = 1'b0;
        bus.exec_dup = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.qed_ifu_instruction !== want[i] || bus.vld_out !== (i < 2)) begin
                n_err++; $display("FAIL resume%0d got %h vld=%b want %h vld=%b", i, bus.qed_ifu_instruction, bus.vld_out, want[i], (i < 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = 32'h00500093;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (bus.dbg_count !== 5'd5) begin n_err++; $display("FAIL pre_reset_count got %0d want 5", bus.dbg_count); end
        bus.stall_IF = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stall_IF = 1'b0;
        n_vec++; if (bus.qed_ifu_instruction !== NOP || bus.vld_out !== 1'b0 || bus.qed_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_reset got %h vld=%b rdy=%b want %h vld=0 rdy=1", bus.qed_ifu_instruction, bus.vld_out, bus.qed_ready, NOP);
        end
        bus.exec_dup = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.qed_ifu_instruction !== NOP || bus.vld_out !== 1'b0) begin
                n_err++; $display("FAIL post_reset_dup%0d got %h vld=%b want %h vld=0", i, bus.qed_ifu_instruction, bus.vld_out, NOP);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.stall_IF = ($urandom_range(0, 9) == 0);
            bus.exec_dup = ($urandom_range(0, 9) < 3);
            bus.ifu_qed_instruction = rand_inst();
            tick();
            n_vec++;
            if (bus.qed_ifu_instruction !== m_out || bus.vld_out !== m_vld || bus.illegal_inst !== m_ill ||
                bus.qed_ready !== (exp_q.size() == 0) || bus.fifo_full !== (exp_q.size() == DEPTH) ||
                int'(bus.dbg_count) != exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d got %h vld=%b ill=%b rdy=%b full=%b cnt=%0d want %h vld=%b ill=%b cnt=%0d",
                         i, bus.qed_ifu_instruction, bus.vld_out, bus.illegal_inst, bus.qed_ready,
                         bus.fifo_full, bus.dbg_count, m_out, m_vld, m_ill, exp_q.size());
            end
        end
        rst = 1'b0;
        bus.stall_IF = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_out = NOP;
        m_vld = 1'b0;
        m_ill = 1'b0;
        rst = 1'b1;
        bus.stall_IF = 1'b0;
        bus.exec_dup = 1'b0;
        bus.ifu_qed_instruction = NOP;
        test_reset();
        test_rtype();
        test_memory();
        test_illegal_nop();
        test_full_wrap();
        test_stall();
        test_reset_mid();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
